// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core memory port between instruction fetch and the LSU.
// One outstanding transaction (IDLE -> ISSUE -> WAIT -> RESP). The LSU has fixed priority,
// and a saturating starvation counter forces a fetch grant after STARVE_LIMIT LSU wins.
// Optional macro MEMARB_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES cycles with an error.
module mem_port_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              ls_req,
    input  logic [XLEN-1:0]   ls_addr,
    input  logic              ls_we,
    input  logic [XLEN/8-1:0] ls_be,
    input  logic [XLEN-1:0]   ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvalid,
    input  logic              mem_err
);

    localparam int unsigned BeW   = XLEN / 8;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
    // Memory is word addressed: the two low address bits never reach the bus.
    localparam logic [XLEN-1:0] AddrMask = ~XLEN'(3);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic                owner_ls_q, owner_ls_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic                we_q, we_d;
    logic [BeW-1:0]      be_q, be_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic                ls_win, if_win;

`ifdef MEMARB_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);
    logic [WaitW-1:0] wait_q, wait_d;
`endif

    // State and latched transaction fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_ls_q <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            starve_q   <= '0;
`ifdef MEMARB_TIMEOUT_EN
            wait_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_ls_q <= owner_ls_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            starve_q   <= starve_d;
`ifdef MEMARB_TIMEOUT_EN
            wait_q     <= wait_d;
`endif
        end
    end

    // Arbitration, grant pulses and next-state sequencing.
    always_comb begin
        state_d    = state_q;
        owner_ls_d = owner_ls_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        starve_d   = starve_q;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
        wait_d     = wait_q;
`endif
        ls_win = ls_req && !(if_req && (starve_q == StarveMax));
        if_win = if_req && !ls_win;

        unique case (state_q)
            StIdle: begin
                if (ls_win) begin
                    // Grants are combinational; gating with rst_n keeps them low during reset.
                    ls_gnt     = rst_n;
                    owner_ls_d = 1'b1;
                    addr_d     = ls_addr;
                    we_d       = ls_we;
                    be_d       = ls_be;
                    wdata_d    = ls_wdata;
                    starve_d   = !if_req ? '0 :
                                 (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
                    if (ls_be == '0) begin
                        // Nothing to access: answer with an error straight away.
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end else if (if_win) begin
                    if_gnt     = rst_n;
                    owner_ls_d = 1'b0;
                    addr_d     = if_addr;
                    we_d       = 1'b0;
                    be_d       = '1;
                    wdata_d    = '0;
                    starve_d   = '0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
`ifdef MEMARB_TIMEOUT_EN
                wait_d = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (mem_rvalid) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    err_d   = mem_err;
                    state_d = StResp;
                end
`ifdef MEMARB_TIMEOUT_EN
                else if (wait_q == WaitLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            StResp: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus and response outputs, forced to zero outside their owning states.
    always_comb begin
        mem_req   = (state_q == StIssue) || (state_q == StWait);
        mem_addr  = mem_req ? (addr_q & AddrMask) : '0;
        mem_we    = mem_req && we_q;
        mem_be    = mem_req ? be_q : '0;
        mem_wdata = mem_req ? wdata_q : '0;
        if_rvalid = (state_q == StResp) && !owner_ls_q;
        ls_rvalid = (state_q == StResp) && owner_ls_q;
        rsp_rdata = (state_q == StResp) ? rdata_q : '0;
        rsp_err   = (state_q == StResp) && err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences (contention, reset mid-WAIT, long WAIT or timeout) and random transactions
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid, mem_err;

    int n_checks = 0;
    int n_errors = 0;
    int model_starve = 0;

    typedef struct {
        logic        ireq;
        logic        lreq;
        logic [31:0] iaddr;
        logic [31:0] laddr;
        logic        lwe;
        logic [3:0]  lbe;
        logic [31:0] lwdata;
        logic [31:0] mrdata;
        logic        merr;
        int          lat;
        int          owner;   // 0 none, 1 fetch, 2 lsu
        logic [31:0] erdata;
        logic        eerr;
    } vec_t;

    mem_port_arbiter #(
        .XLEN(32),
        .STARVE_LIMIT(LIMIT),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_gnt(if_gnt),
        .if_rvalid(if_rvalid),
        .ls_req(ls_req),
        .ls_addr(ls_addr),
        .ls_we(ls_we),
        .ls_be(ls_be),
        .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference rules: LSU wins unless fetch is also waiting and has been passed over
    // STARVE_LIMIT times in a row.
    function automatic int model_owner(input logic ireq, input logic lreq);
        if (lreq && !(ireq && model_starve == LIMIT)) return 2;
        if (ireq) return 1;
        return 0;
    endfunction

    task automatic model_update(input logic ireq, input int owner);
        if (owner == 2 && ireq) model_starve = (model_starve < LIMIT) ? model_starve + 1 : LIMIT;
        else if (owner != 0) model_starve = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " if_gnt"}, if_gnt, 0);
        chk({tag, " ls_gnt"}, ls_gnt, 0);
        chk({tag, " if_rvalid"}, if_rvalid, 0);
        chk({tag, " ls_rvalid"}, ls_rvalid, 0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 0);
        chk({tag, " rsp_err"}, rsp_err, 0);
        chk({tag, " mem_req"}, mem_req, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " mem_be"}, mem_be, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
    endtask

    // One complete transaction starting in IDLE; the loser's request stays asserted
    // throughout to show that nothing is granted while busy.
    task automatic do_txn(input vec_t v, input string tag);
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_we;
        @(negedge clk);
        if_req = v.ireq; if_addr = v.iaddr;
        ls_req = v.lreq; ls_addr = v.laddr; ls_we = v.lwe; ls_be = v.lbe; ls_wdata = v.lwdata;
        mem_rvalid = 1'b0;
        #1;
        chk({tag, " if_gnt"}, if_gnt, v.owner == 1);
        chk({tag, " ls_gnt"}, ls_gnt, v.owner == 2);
        chk({tag, " idle mem_req"}, mem_req, 0);
        model_update(v.ireq, v.owner);
        if (v.owner == 0) return;
        if (v.owner == 1) begin
            e_addr = v.iaddr & 32'hFFFF_FFFC; e_we = 1'b0; e_be = 4'hF; e_wdata = 32'h0;
        end else begin
            e_addr = v.laddr & 32'hFFFF_FFFC; e_we = v.lwe; e_be = v.lbe; e_wdata = v.lwdata;
        end
        @(negedge clk);
        // Winner drops its request and scrambles its inputs; the latched copy must hold.
        if (v.owner == 1) begin if_req = 1'b0; if_addr = $urandom; end
        else begin ls_req = 1'b0; ls_addr = $urandom; ls_wdata = $urandom; ls_be = 4'hF; end
        if (v.owner == 2 && v.lbe == 4'h0) begin
            #1;
            chk({tag, " nobe ls_rvalid"}, ls_rvalid, 1);
            chk({tag, " nobe rsp_err"}, rsp_err, 1);
            chk({tag, " nobe rsp_rdata"}, rsp_rdata, 0);
            chk({tag, " nobe mem_req"}, mem_req, 0);
            return;
        end
        // Spurious completion during ISSUE must be ignored.
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; mem_err = 1'b1;
        #1;
        chk({tag, " issue mem_req"}, mem_req, 1);
        chk({tag, " mem_addr"}, mem_addr, e_addr);
        chk({tag, " mem_we"}, mem_we, e_we);
        chk({tag, " mem_be"}, mem_be, e_be);
        chk({tag, " mem_wdata"}, mem_wdata, e_wdata);
        chk({tag, " busy gnt"}, {if_gnt, ls_gnt}, 0);
        for (int w = 0; w <= v.lat; w++) begin
            @(negedge clk);
            mem_rvalid = (w == v.lat);
            mem_rdata  = (w == v.lat) ? v.mrdata : $urandom;
            mem_err    = v.merr;
            #1;
            chk({tag, " wait mem_req"}, mem_req, 1);
            chk({tag, " wait mem_addr"}, mem_addr, e_addr);
            chk({tag, " wait rvalid"}, {if_rvalid, ls_rvalid}, 0);
        end
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = $urandom; mem_err = 1'b0;
        #1;
        chk({tag, " if_rvalid"}, if_rvalid, v.owner == 1);
        chk({tag, " ls_rvalid"}, ls_rvalid, v.owner == 2);
        chk({tag, " rsp_rdata"}, rsp_rdata, v.erdata);
        chk({tag, " rsp_err"}, rsp_err, v.eerr);
        chk({tag, " resp mem_req"}, mem_req, 0);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   seq[10];

        // ireq lreq iaddr laddr we be wdata mrdata merr lat owner erdata eerr
        tbl[0] = '{1'b1, 1'b0, 32'h0000_0103, 32'h0, 1'b1, 4'h0, 32'h0,
                   32'hDEAD_BEEF, 1'b0, 0, 1, 32'hDEAD_BEEF, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0, 32'h0000_0020, 1'b1, 4'b0100, 32'h00AB_0000,
                   32'h1234_5678, 1'b0, 0, 2, 32'h0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h0, 32'h0000_0040, 1'b0, 4'hF, 32'h0,
                   32'hCAFE_F00D, 1'b1, 1, 2, 32'hCAFE_F00D, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 32'h0, 32'h0000_0050, 1'b0, 4'h0, 32'h0,
                   32'h5555_5555, 1'b0, 0, 2, 32'h0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 32'h0, 32'h0000_0047, 1'b0, 4'b0011, 32'h0,
                   32'h0000_BEEF, 1'b0, 2, 2, 32'h0000_BEEF, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0,
                   32'h0, 1'b0, 0, 0, 32'h0, 1'b0};
        seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

        rst_n = 1'b0;
        if_req = 0; if_addr = 0; ls_req = 0; ls_addr = 0; ls_we = 0; ls_be = 0; ls_wdata = 0;
        mem_rdata = 0; mem_rvalid = 0; mem_err = 0;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

        // Both requesters held: four LSU grants, then fetch, repeating.
        for (int i = 0; i < 10; i++) begin
            v = '{1'b1, 1'b1, 32'h200 + 32'(i * 4), 32'h300, 1'b0, 4'hF, 32'h0,
                  32'(i + 1), 1'b0, 0, seq[i], 32'(i + 1), 1'b0};
            do_txn(v, $sformatf("starve%0d", i));
        end

        // Reset while in WAIT: everything drops at once, no response later.
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h80; ls_we = 1'b0; ls_be = 4'hF;
        #1;
        chk("rst seq ls_gnt", ls_gnt, 1);
        model_update(1'b0, 2);
        @(negedge clk);
        ls_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rst seq wait mem_req", mem_req, 1);
        @(negedge clk);
        rst_n = 1'b0; if_req = 1'b1; ls_req = 1'b1;
        #1;
        chk_quiet("mid-wait reset");
        model_starve = 0;
        @(negedge clk);
        rst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0; mem_rvalid = 1'b1;
        #1;
        chk("post-reset no rvalid", {if_rvalid, ls_rvalid}, 0);
        v = '{1'b1, 1'b0, 32'h0000_0404, 32'h0, 1'b0, 4'h0, 32'h0,
              32'h0BAD_F00D, 1'b0, 0, 1, 32'h0BAD_F00D, 1'b0};
        do_txn(v, "after-reset");

`ifdef MEMARB_TIMEOUT_EN
        // No completion: 16 WAIT cycles, then an error response; a late completion is ignored.
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h90; ls_we = 1'b0; ls_be = 4'hF;
        mem_rvalid = 1'b0;
        #1;
        chk("tmo ls_gnt", ls_gnt, 1);
        model_update(1'b0, 2);
        @(negedge clk);
        ls_req = 1'b0;
        for (int w = 0; w < 16; w++) begin
            @(negedge clk);
            #1;
            chk($sformatf("tmo wait%0d mem_req", w), mem_req, 1);
        end
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("tmo ls_rvalid", ls_rvalid, 1);
        chk("tmo rsp_err", rsp_err, 1);
        chk("tmo rsp_rdata", rsp_rdata, 0);
        chk("tmo mem_req", mem_req, 0);
        @(negedge clk);
        #1;
        chk("tmo late rvalid ignored", {if_rvalid, ls_rvalid, mem_req}, 0);
        mem_rvalid = 1'b0;
`else
        // Without the timeout, a slow memory is simply waited for.
        v = '{1'b0, 1'b1, 32'h0, 32'h0000_00A0, 1'b0, 4'hF, 32'h0,
              32'h7777_1111, 1'b0, 20, 2, 32'h7777_1111, 1'b0};
        do_txn(v, "long-wait");
`endif

        // Random transactions against the reference rules.
        for (int i = 0; i < 300; i++) begin
            v.ireq   = ($urandom_range(0, 3) != 0);
            v.lreq   = ($urandom_range(0, 3) != 0);
            v.iaddr  = $urandom;
            v.laddr  = $urandom;
            v.lwe    = $urandom_range(0, 1) == 1;
            v.lbe    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            v.lwdata = $urandom;
            v.mrdata = $urandom;
            v.merr   = ($urandom_range(0, 5) == 0);
            v.lat    = $urandom_range(0, 3);
            v.owner  = model_owner(v.ireq, v.lreq);
            if (v.owner == 2 && v.lbe == 4'h0) begin
                v.erdata = 32'h0; v.eerr = 1'b1;
            end else begin
                v.erdata = (v.owner == 2 && v.lwe) ? 32'h0 : v.mrdata;
                v.eerr   = v.merr;
            end
            do_txn(v, $sformatf("rand%0d", i));
        end

        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
